sdrc_app_req_q: RTL and testbench

SDRC_APP_REQ_Q -- requirements
Module: sdrc_app_req_q

---
 rtl/sdrc_app_req_q.sv | 97 +++++++++
 tb/tb_sdrc_app_req_q.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdrc_app_req_q.sv
// Application request queue: circular FIFO between the app port and the
// SDRAM request generator, tagging each accepted request with a rolling ID.
module sdrc_app_req_q #(
    parameter int APP_AW = 30,
    parameter int APP_RW = 9,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     app_req,
    input  logic [APP_AW:0]          app_req_addr,
    input  logic [APP_AW-2:0]        app_req_addr_mask,
    input  logic [APP_RW-1:0]        app_req_len,
    input  logic                     app_req_wr_n,
    input  logic                     app_req_wrap,
    output logic                     app_req_ack,
    output logic [ID_W-1:0]          app_req_id,
    input  logic                     sdr_init_done,
    output logic                     req,
    output logic [ID_W-1:0]          req_id,
    output logic [APP_AW:0]          req_addr,
    output logic [APP_AW-2:0]        req_addr_mask,
    output logic [APP_RW-1:0]        req_len,
    output logic                     req_wr_n,
    output logic                     req_wrap,
    input  logic                     req_ack,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     err_zero_len
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ID_W + (APP_AW + 1) + (APP_AW - 1) + APP_RW + 2;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            err_q, err_d;
    logic            zero_len, push, pop;

    assign zero_len    = (app_req_len == '0);
    assign app_req_ack = app_req & (cnt_q != FULL);
    assign push        = app_req_ack & ~zero_len;
    assign req         = (cnt_q != '0) & sdr_init_done;
    assign pop         = req & req_ack;

    assign app_req_id   = id_q;
    assign q_count      = cnt_q;
    assign err_zero_len = err_q;

    assign {req_id, req_addr, req_addr_mask,
            req_len, req_wr_n, req_wrap} = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        err_d    = app_req_ack & zero_len;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (app_req_ack) id_d = id_q + ID_W'(1);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            id_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately left out of reset; cnt_q guards validity.
    always_ff @(posedge clk) begin
        if (reset_n && push)
            mem_q[wr_ptr_q] <= {id_q, app_req_addr, app_req_addr_mask,
                                app_req_len, app_req_wr_n, app_req_wrap};
    end

endmodule

// File: tb/tb_sdrc_app_req_q.sv
// Bench for sdrc_app_req_q: directed scenarios plus a randomized run,
// all checked against a queue-based model of the request FIFO.
module tb_sdrc_app_req_q;

    localparam int AW = 30;
    localparam int RW = 9;
    localparam int IW = 4;
    localparam int D  = 4;
    localparam int MW = AW - 1;
    localparam int AD = AW + 1;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW:0]   addr;
        logic [AW-2:0] mask;
        logic [RW-1:0] len;
        logic          wr_n;
        logic          wrap;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          app_req;
    logic [AW:0]   app_req_addr;
    logic [AW-2:0] app_req_addr_mask;
    logic [RW-1:0] app_req_len;
    logic          app_req_wr_n;
    logic          app_req_wrap;
    logic          app_req_ack;
    logic [IW-1:0] app_req_id;
    logic          sdr_init_done;
    logic          req;
    logic [IW-1:0] req_id;
    logic [AW:0]   req_addr;
    logic [AW-2:0] req_addr_mask;
    logic [RW-1:0] req_len;
    logic          req_wr_n;
    logic          req_wrap;
    logic          req_ack;
    logic [2:0]    q_count;
    logic          err_zero_len;

    ent_t          dut_head;
    ent_t          mq[$];
    logic [IW-1:0] mid;
    logic          merr;
    int            checks = 0;
    int            passes = 0;

    always #5 clk = ~clk;

    assign dut_head = {req_id, req_addr, req_addr_mask,
                       req_len, req_wr_n, req_wrap};

    sdrc_app_req_q #(.APP_AW(AW), .APP_RW(RW), .ID_W(IW), .DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n),
        .app_req(app_req), .app_req_addr(app_req_addr),
        .app_req_addr_mask(app_req_addr_mask), .app_req_len(app_req_len),
        .app_req_wr_n(app_req_wr_n), .app_req_wrap(app_req_wrap),
        .app_req_ack(app_req_ack), .app_req_id(app_req_id),
        .sdr_init_done(sdr_init_done), .req(req), .req_id(req_id),
        .req_addr(req_addr), .req_addr_mask(req_addr_mask),
        .req_len(req_len), .req_wr_n(req_wr_n), .req_wrap(req_wrap),
        .req_ack(req_ack), .q_count(q_count), .err_zero_len(err_zero_len)
    );

    // Called just after a falling edge; outputs are sampled 1 unit later.
    task automatic set_in(input logic a, input logic [AW:0] ad,
                          input logic [RW-1:0] ln, input logic wn,
                          input logic rk, input logic ini);
        app_req           = a;
        app_req_addr      = ad;
        app_req_addr_mask = MW'($urandom);
        app_req_len       = ln;
        app_req_wr_n      = wn;
        app_req_wrap      = 1'($urandom);
        req_ack           = rk;
        sdr_init_done     = ini;
        #1;
    endtask

    // Advance one clock and apply the queue rules to the model.
    task automatic tick();
        bit e_ack, e_req;
        ent_t e;
        e_ack = app_req && (mq.size() < D);
        e_req = (mq.size() != 0) && sdr_init_done;
        e = '{mid, app_req_addr, app_req_addr_mask,
              app_req_len, app_req_wr_n, app_req_wrap};
        @(posedge clk);
        if (!reset_n) begin
            mq.delete();
            mid  = '0;
            merr = 1'b0;
        end else begin
            if (e_req && req_ack) void'(mq.pop_front());
            merr = e_ack && (e.len == '0);
            if (e_ack && e.len != '0) mq.push_back(e);
            if (e_ack) mid = mid + 4'd1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        repeat (n) tick();
        reset_n = 1'b1;
    endtask

    function automatic logic [RW-1:0] rlen();
        return RW'($urandom_range(1, 511));
    endfunction

    task automatic test_reset();
        do_reset(2);
        set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (q_count !== 3'd0) $display("FAIL rst_count: got %0d want 0", q_count);
        else passes++;
        checks++;
        if (req !== 1'b0) $display("FAIL rst_req: got %b want 0", req);
        else passes++;
        checks++;
        if (err_zero_len !== 1'b0) $display("FAIL rst_err: got %b want 0", err_zero_len);
        else passes++;
    endtask

    task automatic test_single();
        set_in(1'b1, AD'(32'h100), 9'd8, 1'b0, 1'b0, 1'b1);
        checks++;
        if (app_req_ack !== 1'b1 || app_req_id !== 4'd0)
            $display("FAIL single_ack: got ack=%b id=%0d want ack=1 id=0", app_req_ack, app_req_id);
        else passes++;
        checks++;
        if (req !== 1'b0) $display("FAIL single_nofall: got req=%b want 0", req);
        else passes++;
        tick();
        set_in(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (req !== 1'b1 || req_id !== 4'd0 || req_addr !== AD'(32'h100) ||
            req_len !== 9'd8 || req_wr_n !== 1'b0)
            $display("FAIL single_head: got req=%b id=%0d addr=%h len=%0d wr_n=%b want 1 0 100 8 0",
                     req, req_id, req_addr, req_len, req_wr_n);
        else passes++;
        checks++;
        if (dut_head !== mq[0]) $display("FAIL single_model: got %h want %h", dut_head, mq[0]);
        else passes++;
        tick();
        set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (req !== 1'b0 || q_count !== 3'd0)
            $display("FAIL single_pop: got req=%b cnt=%0d want 0 0", req, q_count);
        else passes++;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 2 * D && mq.size() != 0; i++) begin
            set_in(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
            checks++;
            if (dut_head !== mq[0]) $display("FAIL %s_drain: got %h want %h", nm, dut_head, mq[0]);
            else passes++;
            tick();
        end
        set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (q_count !== 3'd0) $display("FAIL %s_empty: got %0d want 0", nm, q_count);
        else passes++;
    endtask

    task automatic test_full();
        for (int k = 0; k < D; k++) begin
            set_in(1'b1, AD'($urandom), rlen(), 1'($urandom), 1'b0, 1'b1);
            checks++;
            if (app_req_ack !== 1'b1) $display("FAIL full_ack%0d: got %b want 1", k, app_req_ack);
            else passes++;
            tick();
        end
        set_in(1'b1, AD'($urandom), rlen(), 1'b1, 1'b0, 1'b1);
        checks++;
        if (q_count !== 3'd4 || app_req_ack !== 1'b0)
            $display("FAIL full_block: got cnt=%0d ack=%b want 4 0", q_count, app_req_ack);
        else passes++;
        tick();
        set_in(1'b1, AD'($urandom), rlen(), 1'b1, 1'b1, 1'b1);
        checks++;
        if (app_req_ack !== 1'b0) $display("FAIL full_poppush: got ack=%b want 0", app_req_ack);
        else passes++;
        tick();
        set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (q_count !== 3'd3) $display("FAIL full_pop: got %0d want 3", q_count);
        else passes++;
        drain("full");
    endtask

    task automatic test_wrap_order();
        int popped;
        popped = 0;
        do_reset(1);
        for (int k = 0; k < 10; k++) begin
            set_in(1'b1, AD'($urandom), rlen(), 1'($urandom), k >= 2, 1'b1);
            checks++;
            if (app_req_id !== 4'(k)) $display("FAIL wrap_id%0d: got %0d want %0d", k, app_req_id, k);
            else passes++;
            if (k >= 2) begin
                checks++;
                if (req_id !== 4'(popped) || dut_head !== mq[0])
                    $display("FAIL wrap_head%0d: got id=%0d want %0d", k, req_id, popped);
                else passes++;
                popped++;
            end
            tick();
            set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
            if (k >= 1) begin
                checks++;
                if (q_count !== 3'd2) $display("FAIL wrap_cnt%0d: got %0d want 2", k, q_count);
                else passes++;
            end
        end
        for (int j = 0; j < 2; j++) begin
            set_in(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
            checks++;
            if (req_id !== 4'(popped)) $display("FAIL wrap_tail: got %0d want %0d", req_id, popped);
            else passes++;
            popped++;
            tick();
        end
        drain("wrap");
    endtask

    task automatic test_zero_len();
        logic [IW-1:0] prior;
        logic [2:0]    cnt0;
        set_in(1'b1, AD'($urandom), rlen(), 1'b1, 1'b0, 1'b1);
        prior = app_req_id;
        tick();
        set_in(1'b1, AD'($urandom), 9'd0, 1'b1, 1'b0, 1'b1);
        cnt0 = q_count;
        checks++;
        if (app_req_ack !== 1'b1) $display("FAIL zl_ack: got %b want 1", app_req_ack);
        else passes++;
        tick();
        set_in(1'b1, AD'($urandom), rlen(), 1'b0, 1'b0, 1'b1);
        checks++;
        if (err_zero_len !== 1'b1 || q_count !== cnt0)
            $display("FAIL zl_err: got err=%b cnt=%0d want 1 %0d", err_zero_len, q_count, cnt0);
        else passes++;
        checks++;
        if (app_req_id !== prior + 4'd2)
            $display("FAIL zl_id: got %0d want %0d", app_req_id, prior + 4'd2);
        else passes++;
        tick();
        set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (err_zero_len !== 1'b0) $display("FAIL zl_pulse: got %b want 0", err_zero_len);
        else passes++;
        drain("zl");
    endtask

    task automatic test_init_low();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, AD'($urandom), rlen(), 1'($urandom), 1'b1, 1'b0);
            checks++;
            if (app_req_ack !== 1'b1 || req !== 1'b0)
                $display("FAIL init_push%0d: got ack=%b req=%b want 1 0", k, app_req_ack, req);
            else passes++;
            tick();
        end
        set_in(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (req !== 1'b0 || q_count !== 3'd3)
            $display("FAIL init_hold: got req=%b cnt=%0d want 0 3", req, q_count);
        else passes++;
        tick();
        set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (req !== 1'b1 || dut_head !== mq[0])
            $display("FAIL init_rise: got req=%b head=%h want 1 %h", req, dut_head, mq[0]);
        else passes++;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        set_in(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (q_count !== 3'd0 || req !== 1'b0)
            $display("FAIL rmid_clr: got cnt=%0d req=%b want 0 0", q_count, req);
        else passes++;
        tick();
        set_in(1'b1, AD'($urandom), rlen(), 1'b0, 1'b0, 1'b1);
        checks++;
        if (req !== 1'b0 || app_req_id !== 4'd0)
            $display("FAIL rmid_id: got req=%b id=%0d want 0 0", req, app_req_id);
        else passes++;
        tick();
        drain("rmid");
    endtask

    task automatic test_id_wrap();
        do_reset(1);
        for (int k = 0; k <= 16; k++) begin
            set_in(1'b1, AD'($urandom), rlen(), 1'($urandom), 1'b1, 1'b1);
            checks++;
            if (app_req_ack !== 1'b1 || app_req_id !== 4'(k % 16))
                $display("FAIL idw_%0d: got ack=%b id=%0d want 1 %0d", k, app_req_ack, app_req_id, k % 16);
            else passes++;
            tick();
        end
        drain("idw");
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset_n = ($urandom_range(0, 60) != 0);
            set_in(1'($urandom_range(0, 2) != 0), AD'($urandom),
                   ($urandom_range(0, 9) == 0) ? 9'd0 : rlen(), 1'($urandom),
                   1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) != 0));
            checks++;
            if (app_req_ack !== (app_req && mq.size() < D))
                $display("FAIL rnd_ack c%0d: got %b want %b", c, app_req_ack, app_req && mq.size() < D);
            else passes++;
            if (app_req_ack) begin
                checks++;
                if (app_req_id !== mid) $display("FAIL rnd_id c%0d: got %0d want %0d", c, app_req_id, mid);
                else passes++;
            end
            checks++;
            if (req !== (mq.size() != 0 && sdr_init_done) || q_count !== 3'(mq.size()))
                $display("FAIL rnd_req c%0d: got req=%b cnt=%0d want %b %0d", c, req, q_count,
                         mq.size() != 0 && sdr_init_done, mq.size());
            else passes++;
            checks++;
            if (err_zero_len !== merr) $display("FAIL rnd_err c%0d: got %b want %b", c, err_zero_len, merr);
            else passes++;
            if (mq.size() != 0) begin
                checks++;
                if (dut_head !== mq[0]) $display("FAIL rnd_head c%0d: got %h want %h", c, dut_head, mq[0]);
                else passes++;
            end
            tick();
        end
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        mid     = '0;
        merr    = 1'b0;
        app_req = 1'b0; app_req_addr = '0; app_req_addr_mask = '0;
        app_req_len = '0; app_req_wr_n = 1'b1; app_req_wrap = 1'b0;
        req_ack = 1'b0; sdr_init_done = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_full();
        test_wrap_order();
        test_zero_len();
        test_init_low();
        test_reset_mid();
        test_id_wrap();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
